// File: rtl/pair_triple_pkg.sv
// rtl/pair_triple_pkg.sv - shared vote types and the 2-of-3 majority/unanimity helper
package pair_triple_pkg;

  localparam int VOTE_W   = 3;
  localparam int NREQ_MAX = 8;

  typedef logic [VOTE_W-1:0] vote_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic maj;
    logic unan;
  } vote_res_t;

  function automatic vote_res_t vote_eval(input vote_t v);
    vote_res_t r;
    r.maj  = (v[0] & v[1]) | (v[2] & (v[0] | v[1]));
    r.unan = (&v) | ~(|v);
    return r;
  endfunction

endpackage

// File: rtl/pair_triple_rr_arb.sv
// rtl/pair_triple_rr_arb.sv - rotating-priority arbiter, search starts at ptr and wraps
module pair_triple_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic found;
  int   idx;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    any = found & enable;
    gnt = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/pair_triple_vote_sched.sv
// rtl/pair_triple_vote_sched.sv - round-robin time-shared 2-of-3 vote evaluator with one result slot
// Optional mismatch counter: PAIR_TRIPLE_VOTE_SCHED_MISMATCH_EN
module pair_triple_vote_sched
  import pair_triple_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_val,
  input  logic [VOTE_W*NREQ-1:0] req_votes,
  output logic [NREQ-1:0]        req_rdy,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_maj,
  output logic                   resp_unan,
  output logic                   busy
`ifdef PAIR_TRIPLE_VOTE_SCHED_MISMATCH_EN
  , output logic [CNT_W-1:0]     mismatch_cnt
`endif
);

  if (NREQ < 2 || NREQ > NREQ_MAX || IDW != $clog2(NREQ) || CNT_W < 1) begin : g_param_err
    $error("pair_triple_vote_sched: illegal NREQ/IDW/CNT_W");
  end

  slot_state_e     state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            maj_q, maj_d;
  logic            unan_q, unan_d;
  logic            can_accept;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  vote_t           gnt_vote;
  vote_res_t       gnt_res;

  // Gating with rst_n keeps grants off while reset is held, not just after it.
  assign can_accept = ((state_q == SLOT_EMPTY) || resp_rdy) && rst_n;

  pair_triple_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_val),
    .enable  (can_accept),
    .ptr     (ptr_q),
    .gnt     (req_rdy),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign gnt_vote = req_votes[int'(gnt_idx)*VOTE_W +: VOTE_W];
  assign gnt_res  = vote_eval(gnt_vote);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    maj_d   = maj_q;
    unan_d  = unan_q;
    if (gnt_any) begin
      state_d = SLOT_FULL;
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      id_d    = gnt_idx;
      maj_d   = gnt_res.maj;
      unan_d  = gnt_res.unan;
    end else if (state_q == SLOT_FULL && resp_rdy) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      maj_q   <= 1'b0;
      unan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      maj_q   <= maj_d;
      unan_q  <= unan_d;
    end
  end

  assign resp_val  = (state_q == SLOT_FULL);
  assign busy      = resp_val;
  assign resp_id   = id_q;
  assign resp_maj  = maj_q;
  assign resp_unan = unan_q;

`ifdef PAIR_TRIPLE_VOTE_SCHED_MISMATCH_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counted at accept so a stalled consumer cannot hide disagreements.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_any && !gnt_res.unan && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mismatch_cnt = cnt_q;
`endif

endmodule

// File: doc/pair_triple_vote_sched.md
Name: pair_triple_vote_sched

Overview:
- Time-shares one 3-input pair/triple (2-of-3 majority) evaluator among NREQ requesters.
- Each requester presents a 3-bit vote under valid/ready; a round-robin arbiter admits at most one vote per cycle.
- The admitted vote's majority and unanimity are registered into a single output slot, tagged with the requester id and returned under valid/ready.
- Sits between redundant-channel sources (e.g. TMR lanes) and a single downstream consumer.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- IDW, 2, id width; must equal clog2(NREQ).
- CNT_W, 8, mismatch counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_val  in  NREQ  per-requester vote valid.
- req_votes  in  3*NREQ  requester i vote at bits [3i+2:3i]; bit 3i is in0, bit 3i+2 is in2.
- req_rdy  out  NREQ  one-hot-or-zero grant; a vote transfers when req_val[i] and req_rdy[i] are both high.
- resp_val  out  1  result valid.
- resp_rdy  in  1  consumer ready.
- resp_id  out  IDW  index of the requester that produced the result.
- resp_maj  out  1  1 when at least two of the three vote bits are 1.
- resp_unan  out  1  1 when the vote is 000 or 111.
- busy  out  1  equals resp_val.
- mismatch_cnt  out  CNT_W  present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): resp_val=0, resp_id=0, resp_maj=0, resp_unan=0, rr pointer=0, mismatch_cnt=0. A pending result is discarded. req_rdy=0 while rst_n is low.
- Output slot states: EMPTY (resp_val=0) and FULL (resp_val=1).
  - can_accept = EMPTY, or FULL with resp_rdy=1 (drain and refill in the same cycle).
- Arbitration:
  - Search req_val starting at the pointer, ascending, wrapping modulo NREQ. The first set bit gets req_rdy when can_accept=1.
  - req_rdy is combinational from req_val, pointer and state. It is never asserted for a requester whose req_val is low.
  - On a transfer from index g, the pointer becomes (g+1) mod NREQ. With no transfer the pointer holds.
- Accept: resp_id, resp_maj and resp_unan are loaded from the granted vote at the clock edge; resp_val=1 next cycle.
  - Latency: 1 cycle from transfer to resp_val.
  - Throughput: 1 result/cycle while resp_rdy=1.
- Drain:
  - If resp_val&resp_rdy and no new transfer, the slot goes EMPTY.
  - If resp_val&resp_rdy and a new transfer occurs, the slot stays FULL with the new contents.
- Backpressure: while resp_val=1 and resp_rdy=0, resp_id, resp_maj and resp_unan are held stable and req_rdy=0.
- Majority: maj = (in0&in1) | (in2&(in0|in1)). Unanimity: unan = (in0&in1&in2) | ~(in0|in1|in2).
- No request valid: no grant; the pointer holds.
- Requesters must hold req_val and req_votes stable until granted. The block does not check this.

Optional Feature:
- Macro: PAIR_TRIPLE_VOTE_SCHED_MISMATCH_EN.
- Defined:
  - mismatch_cnt port exists.
  - It increments by 1 on each accepted vote with unan=0, counted at accept time rather than at drain.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pair_triple_pkg holds:
  - vote_t (3-bit typedef).
  - VOTE_W=3.
  - NREQ_MAX=8.
  - a maj/unan helper function, reusable by the bench reference model.
- One sub-module: pair_triple_rr_arb, an NREQ-wide rotating-priority arbiter. Inputs: req, enable, pointer. Outputs: one-hot grant, grant index, any.

Test Plan:
- Reset: hold rst_n=0 with all req_val=1, then release -> req_rdy=0 and resp_val=0 during reset; first grant after release goes to requester 0.
- Truth table: requester 1 alone sends all 8 votes, resp_rdy=1 -> maj=0,0,0,1,0,1,1,1 for 000..111; unan=1 only for 000 and 111; resp_id=1; one result per cycle.
- Round robin: all four req_val=1 continuously, resp_rdy=1 -> grant order 0,1,2,3,0,...; each requester gets exactly 1 of every 4 cycles.
- Backpressure: FULL with id=2 and maj=1, resp_rdy=0 for 5 cycles -> outputs stable, req_rdy=0; resp_rdy=1 -> same-cycle drain and refill, next id=3.
- Async reset mid-operation: rst_n pulled low between edges while FULL -> resp_val=0 immediately; pointer=0 after release.
- Mismatch (with macro, CNT_W=2): five accepted votes of 011 -> mismatch_cnt=1,2,3,3,3; votes of 111 do not change the count.
